ips_dbc_capture_ctrl_v1_1: RTL
==============================

// Module: ips_dbc_capture_ctrl_v1_1
// PURPOSE
//  Capture write controller for the debug core: sits directly upstream of the data capture memory.
//  Drives its write port (wren/wraddress/data) as a circular buffer with a programmable pre-trigger depth.
//  Records the trigger address and the oldest-sample address so the readback logic can unroll the buffer.
//  Holds data until the host re-arms.
// PARAMETERS
//  DATA_DEPTH  9  address width; buffer holds N = 2**DATA_DEPTH samples
//  DATA_WIDTH  8  sample width
// PORTS
//  clk         in   1           sample clock; same clock as the memory write clock
//  rst         in   1           synchronous, active-high reset
//  arm         in   1           start-capture pulse; accepted only in IDLE or DONE
//  abort       in   1           cancel capture; overrides arm
//  pre_len     in   DATA_DEPTH  pre-trigger sample count, latched on accepted arm
//  sample_en   in   1           storage qualifier; only qualified cycles are written
//  trig        in   1           trigger condition from the trigger unit
//  din         in   DATA_WIDTH  probe sample
//  wren        out  1           memory write enable
//  wraddress   out  DATA_DEPTH  memory write address
//  data        out  DATA_WIDTH  memory write data
//  busy        out  1           high in PRE, WAIT_TRIG and POST
//  triggered   out  1           trigger sample has been stored
//  done        out  1           buffer complete; held until accepted arm, abort or rst
//  trig_addr   out  DATA_DEPTH  address of the trigger sample
//  start_addr  out  DATA_DEPTH  address of the oldest sample: trig_addr - pre_len mod N
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0.
//  Write path:
//   - Input at edge n with sample_en=1 and a write-state -> wren=1, wraddress=addr, data=din after edge n.
//   - Latency is exactly 1 cycle. wren is a single-cycle pulse per sample.
//   - addr increments modulo N after every write (natural wrap).
//  States:
//   - IDLE: nothing written.
//     Accepted arm: addr<=0, cnt<=0, pre latched, triggered<=0, done<=0.
//     Goes to PRE, or to WAIT_TRIG if pre_len==0.
//   - PRE: write qualified samples; trig ignored. Go to WAIT_TRIG on the write that makes cnt==pre.
//   - WAIT_TRIG: write qualified samples circularly; may overwrite older ones.
//     On qualified trig (trig & sample_en) the sample is written and trig_addr<=addr, triggered<=1.
//     post_cnt<=N-1-pre, then go to POST; if N-1-pre==0, go to DONE instead.
//     Unqualified trig is ignored.
//   - POST: write qualified samples, post_cnt-1 each; on the write with post_cnt==1 go to DONE.
//   - DONE: no writes; done=1, busy=0; start_addr valid (registered on DONE entry).
//     Accepted arm restarts as from IDLE.
//  Totals: exactly N samples are stored when DONE (pre before trigger, trigger, N-1-pre after).
//  Registered timing: the state change and the final wren occur on the same edge, so done rises with the last wren.
//  Boundary conditions:
//   - arm while busy is ignored.
//   - abort in any state -> IDLE next edge; wren=0, busy=0, triggered=0, done=0; trig_addr/start_addr hold.
//   - arm and abort together -> abort wins.
//   - rst mid-operation -> reset values, IDLE.
//   - sample_en=0 -> no write; addr and counters hold.
//   - pre_len changes while busy have no effect.
// TESTING (DATA_DEPTH=4, N=16, DATA_WIDTH=8; din=sample index, sample_en=1 unless stated)
//  1. pre_len=4, arm, trig with sample 10.
//     -> samples 0-3 at addr 0-3; trig_addr=10; post samples 11-21 at addr 11..15,0..5.
//     -> done with last wren; start_addr=6; mem[6]=6, mem[5]=21.
//  2. pre_len=4, trig held high from arm.
//     -> trig ignored in PRE; trigger taken on sample 4; trig_addr=4; start_addr=0; 11 post writes.
//  3. pre_len=0, trig on first sample -> trig_addr=0, 15 post writes, start_addr=0.
//     pre_len=15, trig on sample 20 -> DONE on the trigger write, no POST.
//  4. sample_en toggling 1,0,1,0 in POST -> one wren per qualified cycle, wraddress contiguous.
//     A trig in a cycle with sample_en=0 does not trigger.
//  5. abort on the 3rd POST write -> IDLE next cycle, wren=0, done=0, busy=0.
//     Re-arm -> first write at addr 0.
//  6. rst in WAIT_TRIG -> all outputs 0; arm pulse in POST -> ignored, capture completes unchanged.

Source files
------------

// File: rtl/ips_dbc_capture_ctrl_v1_1.sv
// Capture write controller for the debug core.
// Drives the capture memory write port as a circular buffer with a
// programmable pre-trigger depth. Records the trigger address and the
// oldest-sample address. Holds the captured data until the host re-arms.
module ips_dbc_capture_ctrl_v1_1 #(
  parameter int DATA_DEPTH = 9,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [DATA_DEPTH-1:0] pre_len,
  input  logic                  sample_en,
  input  logic                  trig,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  wren,
  output logic [DATA_DEPTH-1:0] wraddress,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  busy,
  output logic                  triggered,
  output logic                  done,
  output logic [DATA_DEPTH-1:0] trig_addr,
  output logic [DATA_DEPTH-1:0] start_addr
);

  localparam logic [DATA_DEPTH-1:0] ONE_C  = DATA_DEPTH'(1);
  localparam logic [DATA_DEPTH-1:0] ZERO_C = DATA_DEPTH'(0);
  localparam logic [DATA_DEPTH-1:0] ALL1_C = {DATA_DEPTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_DEPTH-1:0] addr_q, addr_d;
  logic [DATA_DEPTH-1:0] cnt_q, cnt_d;
  logic [DATA_DEPTH-1:0] pre_q, pre_d;
  logic [DATA_DEPTH-1:0] post_cnt_q, post_cnt_d;
  logic                  wren_q, wren_d;
  logic [DATA_DEPTH-1:0] wraddress_q, wraddress_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  busy_q, busy_d;
  logic                  triggered_q, triggered_d;
  logic                  done_q, done_d;
  logic [DATA_DEPTH-1:0] trig_addr_q, trig_addr_d;
  logic [DATA_DEPTH-1:0] start_addr_q, start_addr_d;
  logic                  write_s;
  logic [DATA_DEPTH-1:0] post_len_s;

  // Samples still to be stored after the trigger sample: N-1-pre.
  assign post_len_s = ALL1_C - pre_q;

  // Next-state, write-path and status computation; abort overrides everything.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    pre_d        = pre_q;
    post_cnt_d   = post_cnt_q;
    wren_d       = 1'b0;
    wraddress_d  = wraddress_q;
    data_d       = data_q;
    triggered_d  = triggered_q;
    trig_addr_d  = trig_addr_q;
    start_addr_d = start_addr_q;
    write_s      = 1'b0;

    if (abort) begin
      state_d     = S_IDLE;
      triggered_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            addr_d      = ZERO_C;
            cnt_d       = ZERO_C;
            pre_d       = pre_len;
            triggered_d = 1'b0;
            state_d     = (pre_len == ZERO_C) ? S_WAIT : S_PRE;
          end else begin
            state_d = state_q;
          end
        end
        S_PRE: begin
          // trig is deliberately ignored until the pre-trigger window is full
          if (sample_en) begin
            write_s = 1'b1;
            cnt_d   = cnt_q + ONE_C;
            if (cnt_d == pre_q) begin
              state_d = S_WAIT;
            end else begin
              state_d = S_PRE;
            end
          end else begin
            state_d = S_PRE;
          end
        end
        S_WAIT: begin
          if (sample_en) begin
            write_s = 1'b1;
            if (trig) begin
              trig_addr_d = addr_q;
              triggered_d = 1'b1;
              post_cnt_d  = post_len_s;
              state_d     = (post_len_s == ZERO_C) ? S_DONE : S_POST;
            end else begin
              state_d = S_WAIT;
            end
          end else begin
            state_d = S_WAIT;
          end
        end
        S_POST: begin
          if (sample_en) begin
            write_s    = 1'b1;
            post_cnt_d = post_cnt_q - ONE_C;
            if (post_cnt_q == ONE_C) begin
              state_d = S_DONE;
            end else begin
              state_d = S_POST;
            end
          end else begin
            state_d = S_POST;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase

      if (write_s) begin
        wren_d      = 1'b1;
        wraddress_d = addr_q;
        data_d      = din;
        addr_d      = addr_q + ONE_C;
      end else begin
        wren_d = 1'b0;
      end

      // Oldest sample is pre samples behind the trigger, modulo the buffer size
      if ((state_d == S_DONE) && (state_q != S_DONE)) begin
        start_addr_d = trig_addr_d - pre_q;
      end else begin
        start_addr_d = start_addr_q;
      end
    end

    busy_d = (state_d == S_PRE) || (state_d == S_WAIT) || (state_d == S_POST);
    done_d = (state_d == S_DONE);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      cnt_q        <= '0;
      pre_q        <= '0;
      post_cnt_q   <= '0;
      wren_q       <= 1'b0;
      wraddress_q  <= '0;
      data_q       <= '0;
      busy_q       <= 1'b0;
      triggered_q  <= 1'b0;
      done_q       <= 1'b0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      pre_q        <= pre_d;
      post_cnt_q   <= post_cnt_d;
      wren_q       <= wren_d;
      wraddress_q  <= wraddress_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
      triggered_q  <= triggered_d;
      done_q       <= done_d;
      trig_addr_q  <= trig_addr_d;
      start_addr_q <= start_addr_d;
    end
  end

  assign wren       = wren_q;
  assign wraddress  = wraddress_q;
  assign data       = data_q;
  assign busy       = busy_q;
  assign triggered  = triggered_q;
  assign done       = done_q;
  assign trig_addr  = trig_addr_q;
  assign start_addr = start_addr_q;

endmodule
